// File: rtl/regfile_dump_ctrl.sv
// Register-file dump engine: walks addresses 0..NumRegs-1 through one read port,
// streams each word on a valid/ready interface and accumulates an XOR checksum.
module regfile_dump_ctrl #(
  parameter int RegFileAdd    = 5,
  parameter int RegFile_width = 32,
  parameter int NumRegs       = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic                     Abort,
  output logic [RegFileAdd-1:0]    RegAddr,
  input  logic [RegFile_width-1:0] RegData,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [RegFile_width-1:0] OutData,
  output logic [RegFileAdd-1:0]    OutIndex,
  output logic                     OutLast,
  output logic                     Busy,
  output logic                     Done,
  output logic [RegFile_width-1:0] Checksum
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_t;

  localparam logic [RegFileAdd-1:0] LAST_IDX = RegFileAdd'(NumRegs - 1);

  state_t                     r_state;
  state_t                     w_next;
  logic [RegFileAdd-1:0]      r_idx;
  logic [RegFile_width-1:0]   r_out_data;
  logic [RegFileAdd-1:0]      r_out_index;
  logic                       r_out_last;
  logic [RegFile_width-1:0]   r_checksum;
  logic                       w_hs;

  assign w_hs = (r_state == S_SEND) && OutReady;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Abort wins over everything once a dump is running; Start only matters in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (Start) w_next = S_READ;
      S_READ: w_next = Abort ? S_IDLE : S_SEND;
      S_SEND: begin
        if (Abort)           w_next = S_IDLE;
        else if (w_hs)       w_next = r_out_last ? S_DONE : S_READ;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    RegAddr  = '0;
    OutValid = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (r_state)
      S_READ: begin
        RegAddr = r_idx;
        Busy    = 1'b1;
      end
      S_SEND: begin
        OutValid = 1'b1;
        Busy     = 1'b1;
      end
      S_DONE: begin
        Done = 1'b1;
        Busy = 1'b1;
      end
      default: ;
    endcase
  end

  // A handshake coinciding with Abort still folds the word into the checksum.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_checksum  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_idx      <= '0;
            r_checksum <= '0;
          end
        end
        S_READ: begin
          r_out_data  <= RegData;
          r_out_index <= r_idx;
          r_out_last  <= (r_idx == LAST_IDX);
        end
        S_SEND: begin
          if (w_hs) begin
            r_checksum <= r_checksum ^ r_out_data;
            if (!r_out_last) r_idx <= r_idx + RegFileAdd'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign OutData  = r_out_data;
  assign OutIndex = r_out_index;
  assign OutLast  = r_out_last;
  assign Checksum = r_checksum;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: expected words queued at Start, popped on handshake.
module tb_regfile_dump_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] i;
    logic          l;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Start;
  logic          Abort;
  logic [AW-1:0] RegAddr;
  logic [DW-1:0] RegData;
  logic          OutValid;
  logic          OutReady = 1'b1;
  logic [DW-1:0] OutData;
  logic [AW-1:0] OutIndex;
  logic          OutLast;
  logic          Busy;
  logic          Done;
  logic [DW-1:0] Checksum;

  logic [DW-1:0] regs [NR];
  exp_t          q [$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            rdy_mode = 0;

  regfile_dump_ctrl #(.RegFileAdd(AW), .RegFile_width(DW), .NumRegs(NR)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort),
    .RegAddr(RegAddr), .RegData(RegData),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .OutIndex(OutIndex), .OutLast(OutLast),
    .Busy(Busy), .Done(Done), .Checksum(Checksum)
  );

  always #5 CLK = ~CLK;

  assign RegData = regs[RegAddr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Ready pattern: 0 hold high, 1 random, 2 low, 3 high except while index 10 is offered.
  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      1:       OutReady = ($urandom_range(0, 2) != 0);
      2:       OutReady = 1'b0;
      3:       OutReady = !(OutValid && OutIndex == AW'(10));
      default: OutReady = 1'b1;
    endcase
  end

  // Monitor on the falling edge: stability while stalled, handshakes against the queue, Done pulses.
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_i;
  logic          hold_l;
  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      hold_v = 1'b0;
    end else begin
      if (OutValid && hold_v) begin
        chk("stall_data",  64'(OutData),  64'(hold_d));
        chk("stall_index", 64'(OutIndex), 64'(hold_i));
        chk("stall_last",  64'(OutLast),  64'(hold_l));
      end
      hold_v = OutValid && !OutReady;
      hold_d = OutData;
      hold_i = OutIndex;
      hold_l = OutLast;
      if (OutValid && OutReady) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 64'(1), 64'(0));
        end else begin
          e = q.pop_front();
          chk("word_data",  64'(OutData),  64'(e.d));
          chk("word_index", 64'(OutIndex), 64'(e.i));
          chk("word_last",  64'(OutLast),  64'(e.l));
        end
      end
      if (Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_all();
    exp_t e;
    for (int i = 0; i < NR; i++) begin
      e.d = regs[i];
      e.i = AW'(i);
      e.l = (i == NR - 1);
      q.push_back(e);
    end
  endtask

  task automatic pulse_start(output int c0);
    Start = 1'b1;
    @(posedge CLK); #1;
    c0 = cyc;
    Start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input string tag);
    for (int k = 0; k < 3000; k++) begin
      @(posedge CLK);
      if (done_cnt != n0) break;
    end
    #1;
    chk(tag, 64'(done_cnt - n0), 64'(1));
  endtask

  task automatic wait_index(input int idx);
    for (int k = 0; k < 500; k++) begin
      @(posedge CLK); #1;
      if (OutValid && OutIndex == AW'(idx)) return;
    end
    chk("wait_index_timeout", 64'(1), 64'(0));
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_regaddr"},  64'(RegAddr),  64'(0));
    chk({pfx, "_outvalid"}, 64'(OutValid), 64'(0));
    chk({pfx, "_outdata"},  64'(OutData),  64'(0));
    chk({pfx, "_outindex"}, 64'(OutIndex), 64'(0));
    chk({pfx, "_outlast"},  64'(OutLast),  64'(0));
    chk({pfx, "_busy"},     64'(Busy),     64'(0));
    chk({pfx, "_done"},     64'(Done),     64'(0));
    chk({pfx, "_checksum"}, 64'(Checksum), 64'(0));
  endtask

  initial begin
    int c0;
    int n0;
    logic [DW-1:0] part;
    RST = 1'b0; Start = 1'b0; Abort = 1'b0;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    #12;
    check_all_zero("reset");
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Single nonzero register, ready held high, latency from Start edge
    regs[5] = 32'hDEADBEEF;
    rdy_mode = 0;
    push_all();
    n0 = done_cnt;
    pulse_start(c0);
    wait_done(n0, "t1_done");
    chk("t1_done_latency", 64'(done_cyc - c0), 64'(64));
    chk("t1_checksum", 64'(Checksum), 64'h0000_0000_DEAD_BEEF);
    chk("t1_queue_empty", 64'(q.size()), 64'(0));
    chk("t1_idle", 64'(Busy), 64'(0));

    // Distinct values in every register
    for (int i = 0; i < NR; i++) regs[i] = 32'h100 + 32'(i);
    push_all();
    n0 = done_cnt;
    pulse_start(c0);
    wait_done(n0, "t2_done");
    chk("t2_checksum", 64'(Checksum), 64'(0));
    chk("t2_queue_empty", 64'(q.size()), 64'(0));

    // Random backpressure
    rdy_mode = 1;
    push_all();
    n0 = done_cnt;
    pulse_start(c0);
    wait_done(n0, "t3_done");
    chk("t3_checksum", 64'(Checksum), 64'(0));
    chk("t3_queue_empty", 64'(q.size()), 64'(0));
    rdy_mode = 0;
    @(posedge CLK); #1;

    // Abort while index 10 is stalled
    rdy_mode = 3;
    push_all();
    n0 = done_cnt;
    pulse_start(c0);
    wait_index(10);
    Abort = 1'b1;
    @(posedge CLK); #1;
    Abort = 1'b0;
    part = '0;
    for (int i = 0; i < 10; i++) part = part ^ regs[i];
    chk("t4_outvalid", 64'(OutValid), 64'(0));
    chk("t4_busy", 64'(Busy), 64'(0));
    chk("t4_checksum", 64'(Checksum), 64'(part));
    chk("t4_words_left", 64'(q.size()), 64'(22));
    q.delete();
    repeat (3) @(posedge CLK);
    #1;
    chk("t4_no_done", 64'(done_cnt - n0), 64'(0));
    rdy_mode = 0;
    push_all();
    pulse_start(c0);
    chk("t4_restart_busy", 64'(Busy), 64'(1));
    chk("t4_restart_cksum", 64'(Checksum), 64'(0));
    chk("t4_restart_addr", 64'(RegAddr), 64'(0));
    wait_done(n0, "t4_restart_done");
    chk("t4_restart_final", 64'(Checksum), 64'(0));

    // Start pulsed mid-dump is ignored
    regs[7] = 32'h0F0F_1234;
    push_all();
    n0 = done_cnt;
    pulse_start(c0);
    wait_index(3);
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done(n0, "t5_done");
    repeat (6) @(posedge CLK);
    #1;
    chk("t5_single_done", 64'(done_cnt - n0), 64'(1));
    chk("t5_idle", 64'(Busy), 64'(0));
    chk("t5_checksum", 64'(Checksum), 64'(32'h0F0F_1234 ^ (32'h100 + 32'd7)));
    chk("t5_queue_empty", 64'(q.size()), 64'(0));

    // Asynchronous reset while index 20 is offered
    push_all();
    n0 = done_cnt;
    pulse_start(c0);
    wait_index(20);
    #1;
    RST = 1'b0;
    #1;
    check_all_zero("t6_async");
    chk("t6_words_left", 64'(q.size()), 64'(12));
    q.delete();
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("t6_stay_idle", 64'(Busy), 64'(0));
    chk("t6_no_valid", 64'(OutValid), 64'(0));
    chk("t6_no_done", 64'(done_cnt - n0), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
